// File: rtl/spi_reg_writer.sv
// SPI mode-0 byte receiver driving a 3-bit address / 5-bit data register write port.
// Ports: clk, rst (sync, active-high); cs_n, sclk, mosi (async pins);
//        write_strobe, address[2:0], data[4:0], busy, frame_err (registered outputs).
module spi_reg_writer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       sclk,
    input  logic       mosi,
    output logic       write_strobe,
    output logic [2:0] address,
    output logic [4:0] data,
    output logic       busy,
    output logic       frame_err
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam int SW = $clog2(SYNC_STAGES + 2);
    localparam logic [SW-1:0] SETTLED = SW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   cs_prev_q;
    logic                   sclk_prev_q;
    logic [SW-1:0]          settle_q;

    logic cs_s;
    logic sclk_s;
    logic mosi_s;
    logic armed;
    logic cs_fall;
    logic cs_rise;
    logic sclk_rise;

    state_t     state_q;
    logic [2:0] cnt_q;
    logic [7:0] sr_q;
    logic [7:0] sr_d;
    logic       done_q;
    logic       strobe_q;
    logic [2:0] addr_q;
    logic [4:0] data_q;
    logic       busy_q;
    logic       ferr_q;

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Reset preloads the chains, so a cs_n held low through reset would
    // look like a fall once the pin value arrives. Edges are only trusted
    // after the chain and history have been refilled from the pins.
    assign armed     = (settle_q == SETTLED);
    assign cs_fall   = armed & cs_prev_q & ~cs_s;
    assign cs_rise   = armed & ~cs_prev_q & cs_s;
    assign sclk_rise = armed & ~sclk_prev_q & sclk_s;

    assign sr_d = {sr_q[6:0], mosi_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            settle_q    <= '0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
            if (!armed) begin
                settle_q <= settle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sr_q     <= '0;
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            ferr_q   <= 1'b0;
            done_q   <= 1'b0;
            // A completed byte is flagged first, then issued one cycle later
            // from the settled shift register.
            if (done_q) begin
                strobe_q <= 1'b1;
                addr_q   <= sr_q[7:5];
                data_q   <= sr_q[4:0];
            end
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    // cs_rise takes priority over a coincident sclk_rise.
                    if (cs_rise) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (cnt_q != 3'd0) begin
                            ferr_q <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        sr_q  <= sr_d;
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            done_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign write_strobe = strobe_q;
    assign address      = addr_q;
    assign data         = data_q;
    assign busy         = busy_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_spi_reg_writer.sv
// Scoreboard bench for spi_reg_writer: directed SPI frames, expected writes
// queued at issue time and popped by a monitor on each write_strobe.
module tb_spi_reg_writer;

    localparam int S    = 2;
    localparam int HALF = S + 2;

    typedef struct {
        logic [2:0] addr;
        logic [4:0] data;
        int         rise_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs_n = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       write_strobe;
    logic [2:0] address;
    logic [4:0] data;
    logic       busy;
    logic       frame_err;

    exp_t exp_q[$];
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    int   strobes = 0;
    int   ferrs = 0;
    bit   busy_seen = 1'b0;

    spi_reg_writer #(.SYNC_STAGES(S)) dut (
        .clk(clk),
        .rst(rst),
        .cs_n(cs_n),
        .sclk(sclk),
        .mosi(mosi),
        .write_strobe(write_strobe),
        .address(address),
        .data(data),
        .busy(busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per strobe and checks content and latency.
    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_seen = 1'b1;
        if (frame_err) ferrs++;
        if (write_strobe) begin
            strobes++;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_addr", int'(address), int'(e.addr));
                check("strobe_data", int'(data), int'(e.data));
                check("strobe_latency", cyc - e.rise_cyc, S + 2);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input bit push);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            wait_cyc(HALF);
            sclk = 1'b1;
            if (push && i == 7) begin
                e.addr = b[7:5];
                e.data = b[4:0];
                e.rise_cyc = cyc;
                exp_q.push_back(e);
            end
            wait_cyc(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] b);
        cs_n = 1'b0;
        wait_cyc(HALF);
        send_bits(b, 8, 1'b1);
        wait_cyc(HALF);
        cs_n = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    initial begin
        wait_cyc(3);
        rst = 1'b0;
        check("rst_strobe", int'(write_strobe), 0);
        check("rst_addr", int'(address), 0);
        check("rst_data", int'(data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ferr", int'(frame_err), 0);
        wait_cyc(2 * HALF);

        // 1: single 0x45 frame
        cs_n = 1'b0;
        wait_cyc(HALF);
        check("t1_busy_high", int'(busy), 1);
        send_bits(8'h45, 8, 1'b1);
        wait_cyc(HALF);
        cs_n = 1'b1;
        wait_cyc(2 * HALF);
        check("t1_busy_low", int'(busy), 0);
        check("t1_strobes", strobes, 1);
        check("t1_ferr", ferrs, 0);

        // 2: burst 0x0A, 0xBF
        cs_n = 1'b0;
        wait_cyc(HALF);
        send_bits(8'h0A, 8, 1'b1);
        send_bits(8'hBF, 8, 1'b1);
        wait_cyc(HALF);
        cs_n = 1'b1;
        wait_cyc(2 * HALF);
        check("t2_strobes", strobes, 3);
        check("t2_hold_addr", int'(address), 5);
        check("t2_hold_data", int'(data), 31);

        // 3: aborted 5-bit frame, then 0x61
        cs_n = 1'b0;
        wait_cyc(HALF);
        send_bits(8'h12, 5, 1'b0);
        wait_cyc(HALF);
        cs_n = 1'b1;
        wait_cyc(2 * HALF);
        check("t3_ferr", ferrs, 1);
        check("t3_strobes", strobes, 3);
        check("t3_keep_addr", int'(address), 5);
        check("t3_keep_data", int'(data), 31);
        frame(8'h61);
        check("t3_strobes2", strobes, 4);

        // 4a: sclk toggling with cs_n high
        busy_seen = 1'b0;
        send_bits(8'hFF, 8, 1'b0);
        wait_cyc(2 * HALF);
        check("t4a_strobes", strobes, 4);
        check("t4a_busy", int'(busy_seen), 0);

        // 4b: cs_n low across reset release
        cs_n = 1'b0;
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        busy_seen = 1'b0;
        wait_cyc(2 * HALF);
        send_bits(8'hFF, 8, 1'b0);
        wait_cyc(2 * HALF);
        check("t4b_strobes", strobes, 4);
        check("t4b_busy", int'(busy_seen), 0);
        cs_n = 1'b1;
        wait_cyc(2 * HALF);
        frame(8'hA7);
        check("t4_strobes", strobes, 5);
        check("t4_addr", int'(address), 5);
        check("t4_data", int'(data), 7);

        // 5: reset after 4 bits
        cs_n = 1'b0;
        wait_cyc(HALF);
        send_bits(8'hF0, 4, 1'b0);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        check("t5_addr", int'(address), 0);
        check("t5_data", int'(data), 0);
        check("t5_busy", int'(busy), 0);
        wait_cyc(2 * HALF);
        send_bits(8'hFF, 8, 1'b0);
        wait_cyc(2 * HALF);
        check("t5_strobes", strobes, 5);
        check("t5_ferr", ferrs, 1);
        cs_n = 1'b1;
        wait_cyc(2 * HALF);
        frame(8'h45);
        check("t5_recover", strobes, 6);

        // 6: cs_n rise together with 8th sclk rise
        cs_n = 1'b0;
        wait_cyc(HALF);
        send_bits(8'hFE, 7, 1'b0);
        mosi = 1'b1;
        wait_cyc(HALF);
        sclk = 1'b1;
        cs_n = 1'b1;
        wait_cyc(HALF);
        sclk = 1'b0;
        wait_cyc(2 * HALF);
        check("t6_ferr", ferrs, 2);
        check("t6_strobes", strobes, 6);
        check("t6_keep_addr", int'(address), 2);
        check("t6_keep_data", int'(data), 5);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
